// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel path: colour depth, register map
// and bit positions of the STATUS and CONTROL registers.
package vga_pkg;

    localparam int VGA_COLOR_DEPTH = 4;
    localparam int VGA_PW          = 3 * VGA_COLOR_DEPTH;

    // Avalon register word addresses
    typedef enum logic [1:0] {
        REG_DATA    = 2'd0,
        REG_STATUS  = 2'd1,
        REG_CONTROL = 2'd2,
        REG_RSVD    = 2'd3
    } vga_reg_e;

    // STATUS register bit positions (level occupies the low AW+1 bits)
    localparam int STAT_EMPTY_BIT = 8;
    localparam int STAT_FULL_BIT  = 9;
    localparam int STAT_UF_BIT    = 10;

    // CONTROL register bit positions
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_CLR_UF_BIT = 1;
    localparam int CTRL_FLUSH_BIT  = 2;

endpackage

// File: rtl/vga_fifo_mem.sv
// Pixel storage: DEPTH x PW array with one write port and one registered
// read port. The read register doubles as the pixel output register, so it
// also supports a synchronous clear and otherwise holds its value.
module vga_fifo_mem #(
    parameter int PW    = 12,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [PW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic          rd_clr_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [PW-1:0] rd_data_o
);

    logic [PW-1:0] mem [DEPTH];
    logic [PW-1:0] rdData_q;

    // Array write; contents are never reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read: load on a pop, zero on a refused request, else hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdData_q <= '0;
        end else if (rd_en_i) begin
            rdData_q <= mem[rd_addr_i];
        end else if (rd_clr_i) begin
            rdData_q <= '0;
        end
    end

    assign rd_data_o = rdData_q;

endmodule

// File: rtl/vga_pixel_fifo.sv
// Avalon-MM slave pixel FIFO feeding the VGA timing core. The bus pushes
// packed {b,g,r} pixels, the VGA core pops one per active-video clock, and
// a sticky flag records any request that found the FIFO empty.
module vga_pixel_fifo
    import vga_pkg::*;
#(
    parameter int COLOR_DEPTH = VGA_COLOR_DEPTH,
    parameter int DEPTH       = 16,
    parameter int AW          = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               avs_address,
    input  logic                     avs_write,
    input  logic [31:0]              avs_writedata,
    input  logic                     avs_read,
    output logic [31:0]              avs_readdata,
    output logic                     avs_waitrequest,
    input  logic                     pix_req,
    output logic [3*COLOR_DEPTH-1:0] pixel,
    output logic                     pixel_valid,
    output logic                     underflow
);

    localparam int PW    = 3 * COLOR_DEPTH;
    localparam int LVL_W = AW + 1;

    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             en_q, en_d;
    logic             uflow_q, uflow_d;
    logic             pixelValid_q, pixelValid_d;
    logic [31:0]      readData_q, readData_d;

    logic        full, empty, ctrlWr, flush, push, pop, uflowEvent, pixClr;
    logic [31:0] statusWord;
    logic        unused_wd;

    // Upper write-data bits carry nothing for either writable register
    assign unused_wd = ^avs_writedata[31:PW];

    // Bus decode and push/pop qualification; a flush overrides both
    always_comb begin
        full            = (level_q == LVL_W'(DEPTH));
        empty           = (level_q == '0);
        ctrlWr          = avs_write & (avs_address == REG_CONTROL);
        flush           = ctrlWr & avs_writedata[CTRL_FLUSH_BIT];
        avs_waitrequest = avs_write & (avs_address == REG_DATA) & full;
        push            = avs_write & (avs_address == REG_DATA) & ~full & ~flush;
        pop             = pix_req & en_q & ~empty & ~flush;
        uflowEvent      = pix_req & en_q & empty & ~flush;
        pixClr          = pix_req & ~pop & ~flush;
        statusWord                 = '0;
        statusWord[LVL_W-1:0]      = level_q;
        statusWord[STAT_EMPTY_BIT] = empty;
        statusWord[STAT_FULL_BIT]  = full;
        statusWord[STAT_UF_BIT]    = uflow_q;
    end

    // Next-state for pointers, level, control, sticky flag and read data
    always_comb begin
        wrPtr_d      = wrPtr_q;
        rdPtr_d      = rdPtr_q;
        level_d      = level_q;
        en_d         = en_q;
        uflow_d      = uflow_q;
        pixelValid_d = pop;
        readData_d   = readData_q;

        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            level_d = '0;
        end else begin
            if (push) begin
                wrPtr_d = wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + 1'b1;
            end
            if (push && !pop) begin
                level_d = level_q + 1'b1;
            end else if (pop && !push) begin
                level_d = level_q - 1'b1;
            end
        end

        if (ctrlWr) begin
            en_d = avs_writedata[CTRL_EN_BIT];
        end

        if (uflowEvent) begin
            uflow_d = 1'b1;
        end else if (ctrlWr && avs_writedata[CTRL_CLR_UF_BIT]) begin
            uflow_d = 1'b0;
        end

        if (avs_read) begin
            case (avs_address)
                REG_STATUS:  readData_d = statusWord;
                REG_CONTROL: readData_d = {31'b0, en_q};
                default:     readData_d = '0;
            endcase
        end
    end

    // State registers, cleared asynchronously so reset drops all contents
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            level_q      <= '0;
            en_q         <= 1'b0;
            uflow_q      <= 1'b0;
            pixelValid_q <= 1'b0;
            readData_q   <= '0;
        end else begin
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            level_q      <= level_d;
            en_q         <= en_d;
            uflow_q      <= uflow_d;
            pixelValid_q <= pixelValid_d;
            readData_q   <= readData_d;
        end
    end

    vga_fifo_mem #(
        .PW    (PW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (push),
        .wr_addr_i (wrPtr_q),
        .wr_data_i (avs_writedata[PW-1:0]),
        .rd_en_i   (pop),
        .rd_clr_i  (pixClr),
        .rd_addr_i (rdPtr_q),
        .rd_data_o (pixel)
    );

    assign pixel_valid  = pixelValid_q;
    assign underflow    = uflow_q;
    assign avs_readdata = readData_q;

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// Directed bench for vga_pixel_fifo: reset, fill/drain, full stall,
// underflow handling, simultaneous push/pop, pointer wrap and flush.
module tb_vga_pixel_fifo;

    localparam logic [1:0] A_DATA    = 2'd0;
    localparam logic [1:0] A_STATUS  = 2'd1;
    localparam logic [1:0] A_CONTROL = 2'd2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  avs_address = '0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic        pix_req = 1'b0;
    logic [11:0] pixel;
    logic        pixel_valid;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    vga_pixel_fifo #(
        .COLOR_DEPTH (4),
        .DEPTH       (16),
        .AW          (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .avs_address     (avs_address),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_read        (avs_read),
        .avs_readdata    (avs_readdata),
        .avs_waitrequest (avs_waitrequest),
        .pix_req         (pix_req),
        .pixel           (pixel),
        .pixel_valid     (pixel_valid),
        .underflow       (underflow)
    );

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        tick();
        avs_write     = 1'b0;
        avs_writedata = '0;
    endtask

    task automatic busRead(input logic [1:0] addr, output logic [31:0] data);
        avs_address = addr;
        avs_read    = 1'b1;
        tick();
        avs_read    = 1'b0;
        data        = avs_readdata;
    endtask

    task automatic checkStatus(input string tag, input logic [31:0] expected);
        logic [31:0] d;
        busRead(A_STATUS, d);
        checkOutput(tag, d, expected);
    endtask

    task automatic popOne(input string tag, input logic [11:0] expected);
        pix_req = 1'b1;
        tick();
        pix_req = 1'b0;
        checkOutput({tag, "_pix"}, 32'(pixel), 32'(expected));
        checkOutput({tag, "_vld"}, 32'(pixel_valid), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [11:0] model[$];
        logic [11:0] v;
        logic [11:0] lastPix;
        int n;

        $display("[TB] start");

        // Power-on reset
        repeat (2) tick();
        checkOutput("rst_pix", 32'(pixel), 32'd0);
        checkOutput("rst_vld", 32'(pixel_valid), 32'd0);
        checkOutput("rst_uf", 32'(underflow), 32'd0);
        checkOutput("rst_rdata", avs_readdata, 32'd0);
        reset = 1'b0;
        checkStatus("rst_status", 32'h100);

        // Reset mid-stream, including a DATA write with junk upper bits
        applyStimulus(A_CONTROL, 32'h1);
        applyStimulus(A_DATA, 32'hFFFF_FABC);
        applyStimulus(A_DATA, 32'h123);
        popOne("midrst_pop", 12'hABC);
        #2 reset = 1'b1;
        #1;
        checkOutput("midrst_pix", 32'(pixel), 32'd0);
        checkOutput("midrst_vld", 32'(pixel_valid), 32'd0);
        #1 reset = 1'b0;
        checkStatus("midrst_status", 32'h100);
        busRead(A_CONTROL, rd);
        checkOutput("midrst_en", rd, 32'd0);

        // Fill and drain three pixels
        applyStimulus(A_CONTROL, 32'h1);
        applyStimulus(A_DATA, 32'h00F);
        applyStimulus(A_DATA, 32'h0F0);
        applyStimulus(A_DATA, 32'hF00);
        checkStatus("fill_status", 32'h003);
        popOne("drain0", 12'h00F);
        popOne("drain1", 12'h0F0);
        popOne("drain2", 12'hF00);
        tick();
        checkOutput("idle_vld", 32'(pixel_valid), 32'd0);
        checkOutput("idle_hold", 32'(pixel), 32'hF00);
        checkStatus("drain_status", 32'h100);

        // Fill to 16, then a 17th write stalls until a pop frees a slot
        for (int i = 0; i < 16; i++) begin
            applyStimulus(A_DATA, 32'h100 + 32'(i));
        end
        checkStatus("full_status", 32'h210);
        avs_address   = A_DATA;
        avs_writedata = 32'h777;
        avs_write     = 1'b1;
        #1;
        checkOutput("stall_wr0", 32'(avs_waitrequest), 32'd1);
        tick();
        checkOutput("stall_wr1", 32'(avs_waitrequest), 32'd1);
        pix_req = 1'b1;
        tick();
        pix_req = 1'b0;
        checkOutput("stall_pop_pix", 32'(pixel), 32'h100);
        checkOutput("stall_pop_vld", 32'(pixel_valid), 32'd1);
        checkOutput("stall_release", 32'(avs_waitrequest), 32'd0);
        tick();
        avs_write     = 1'b0;
        avs_writedata = '0;
        checkStatus("stall_status", 32'h210);
        pix_req = 1'b1;
        for (int i = 1; i < 16; i++) begin
            tick();
            checkOutput("full_drain", 32'(pixel), 32'h100 + 32'(i));
        end
        tick();
        pix_req = 1'b0;
        checkOutput("full_last", 32'(pixel), 32'h777);
        checkStatus("full_empty", 32'h100);

        // Underflow, set-over-clear priority, clear, and disabled requests
        pix_req = 1'b1;
        tick();
        pix_req = 1'b0;
        checkOutput("uf_pix", 32'(pixel), 32'd0);
        checkOutput("uf_vld", 32'(pixel_valid), 32'd0);
        checkOutput("uf_flag", 32'(underflow), 32'd1);
        checkStatus("uf_status", 32'h500);
        pix_req = 1'b1;
        applyStimulus(A_CONTROL, 32'h3);
        pix_req = 1'b0;
        checkOutput("uf_set_wins", 32'(underflow), 32'd1);
        applyStimulus(A_CONTROL, 32'h3);
        checkOutput("uf_cleared", 32'(underflow), 32'd0);
        checkStatus("uf_clr_status", 32'h100);
        busRead(A_CONTROL, rd);
        checkOutput("uf_en_kept", rd, 32'd1);
        applyStimulus(A_CONTROL, 32'h0);
        applyStimulus(A_DATA, 32'h5A5);
        pix_req = 1'b1;
        tick();
        pix_req = 1'b0;
        checkOutput("dis_vld", 32'(pixel_valid), 32'd0);
        checkOutput("dis_uf", 32'(underflow), 32'd0);
        checkStatus("dis_status", 32'h001);
        applyStimulus(A_CONTROL, 32'h1);

        // Simultaneous push and pop at level 5, then on an empty FIFO
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(A_DATA, 32'(i));
        end
        avs_address   = A_DATA;
        avs_writedata = 32'h5;
        avs_write     = 1'b1;
        pix_req       = 1'b1;
        tick();
        avs_write     = 1'b0;
        pix_req       = 1'b0;
        checkOutput("sim_pix", 32'(pixel), 32'h5A5);
        checkOutput("sim_vld", 32'(pixel_valid), 32'd1);
        checkStatus("sim_level", 32'h005);
        for (int i = 1; i <= 5; i++) begin
            popOne("sim_order", 12'(i));
        end
        avs_address   = A_DATA;
        avs_writedata = 32'h0AA;
        avs_write     = 1'b1;
        pix_req       = 1'b1;
        tick();
        avs_write     = 1'b0;
        pix_req       = 1'b0;
        checkOutput("sim_e_vld", 32'(pixel_valid), 32'd0);
        checkOutput("sim_e_uf", 32'(underflow), 32'd1);
        checkStatus("sim_e_status", 32'h401);
        applyStimulus(A_CONTROL, 32'h3);
        popOne("sim_e_data", 12'h0AA);
        checkStatus("sim_e_empty", 32'h100);

        // Pointer wrap over 40 pixels against a queue model
        n = 0;
        lastPix = '0;
        for (int blk = 0; blk < 4; blk++) begin
            for (int j = 0; j < 10; j++) begin
                v = 12'((n * 37 + 5) % 4096);
                n++;
                model.push_back(v);
                applyStimulus(A_DATA, 32'(v));
            end
            for (int j = 0; j < 10; j++) begin
                lastPix = model.pop_front();
                popOne("wrap", lastPix);
            end
        end

        // Flush drops queued pixels but leaves the pixel output alone
        applyStimulus(A_DATA, 32'h111);
        applyStimulus(A_DATA, 32'h222);
        applyStimulus(A_DATA, 32'h333);
        applyStimulus(A_CONTROL, 32'h5);
        checkStatus("flush_status", 32'h100);
        checkOutput("flush_pix", 32'(pixel), 32'(lastPix));
        busRead(A_CONTROL, rd);
        checkOutput("flush_en", rd, 32'd1);
        pix_req = 1'b1;
        tick();
        pix_req = 1'b0;
        checkOutput("flush_vld", 32'(pixel_valid), 32'd0);
        checkOutput("flush_uf", 32'(underflow), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
